// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch-stage bus bundle covering the PC-stage, instruction
// memory and decode sides. 'master' is the fetch stage's view, 'slave' the
// view of the surrounding pipeline / memory.
interface inst_fetch_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_i;
  logic              flush;
  logic              fetch_stall_o;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [31:0]       imem_rdata_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [31:0]       id_inst_o;
  logic [ADDR_W-1:0] id_pc_o;

  modport master (
    input  pc_i, flush, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    output fetch_stall_o, imem_req_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o
  );

  modport slave (
    output pc_i, flush, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    input  fetch_stall_o, imem_req_o, imem_addr_o, id_valid_o, id_inst_o, id_pc_o
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage between the PC generator and decode.
// Issues in-order instruction-memory requests, keeps granted fetches in a
// DEPTH-entry ring buffer of {pc, inst, dv} and hands completed entries to
// decode over valid/ready. A flush empties the buffer and counts the
// responses still owed by memory so they can be discarded on arrival.
// Optional feature: define INST_FETCH_BYPASS_EN to forward a response that
// fills the head entry straight to decode in the same cycle.
module inst_fetch #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [DEPTH-1:0]  dv;

  // wr: next slot to allocate; fill: oldest slot still awaiting data;
  // rd: head slot handed to decode. rd <= fill <= wr in ring order.
  logic [PW-1:0] wr_ptr, rd_ptr, fill_ptr, drop_cnt;
  logic [PW-1:0] alloc_cnt, inflight;
  logic [PW:0]   occupancy;
  logic [IW-1:0] wr_idx, rd_idx, fill_idx;

  logic req, grant, pending, drop_rsp, fill_rsp, rsp_used;
  logic bypass, id_valid, retire;
  logic [31:0]       id_inst;
  logic [ADDR_W-1:0] id_pc;

  // Occupancy bookkeeping and request issue.
  always_comb begin
    alloc_cnt = wr_ptr - rd_ptr;
    inflight  = wr_ptr - fill_ptr;
    occupancy = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    wr_idx    = wr_ptr[IW-1:0];
    rd_idx    = rd_ptr[IW-1:0];
    fill_idx  = fill_ptr[IW-1:0];
    req       = rst & ~bus.flush & (occupancy < DEPTH_C);
    grant     = req & bus.imem_gnt_i;
  end

  // Response classification and the decode-side view of the head entry.
  always_comb begin
    pending  = (inflight != '0);
    drop_rsp = bus.imem_rvalid_i & (drop_cnt != '0);
    fill_rsp = bus.imem_rvalid_i & (drop_cnt == '0) & pending;
    rsp_used = drop_rsp | fill_rsp;
`ifdef INST_FETCH_BYPASS_EN
    bypass   = fill_rsp & (fill_ptr == rd_ptr);
`else
    bypass   = 1'b0;
`endif
    id_valid = dv[rd_idx] | bypass;
    id_inst  = bypass ? bus.imem_rdata_i : inst_mem[rd_idx];
    id_pc    = pc_mem[rd_idx];
    retire   = id_valid & bus.id_ready_i;
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = bus.pc_i;
  assign bus.fetch_stall_o = ~grant;
  assign bus.id_valid_o    = id_valid;
  assign bus.id_inst_o     = id_inst;
  assign bus.id_pc_o       = id_pc;

  // Pointer, drop-count and data-valid state.
  // Slot conflicts cannot occur: grant and fill share a slot only when the
  // buffer is empty or full, and fill/retire share one only when bypassing,
  // in which case a retiring bypassed entry never gets its dv set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_ptr <= '0;
      drop_cnt <= '0;
      dv       <= '0;
    end else if (bus.flush) begin
      rd_ptr   <= wr_ptr;
      fill_ptr <= wr_ptr;
      dv       <= '0;
      drop_cnt <= drop_cnt + inflight - PW'(rsp_used);
    end else begin
      if (grant) begin
        dv[wr_idx] <= 1'b0;
        wr_ptr     <= wr_ptr + PW'(1);
      end
      if (drop_rsp) begin
        drop_cnt <= drop_cnt - PW'(1);
      end
      if (fill_rsp) begin
        fill_ptr <= fill_ptr + PW'(1);
        if (!(bypass & bus.id_ready_i)) begin
          dv[fill_idx] <= 1'b1;
        end
      end
      if (retire) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (!bypass) begin
          dv[rd_idx] <= 1'b0;
        end
      end
    end
  end

  // Entry payload: pc captured on grant, instruction captured on fill.
  always_ff @(posedge clk) begin
    if (rst && !bus.flush && grant) begin
      pc_mem[wr_idx] <= bus.pc_i;
    end
    if (rst && !bus.flush && fill_rsp) begin
      inst_mem[fill_idx] <= bus.imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a queue-based reference
// model checked every cycle, plus hand-computed expectations per scenario.
module tb_inst_fetch;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
`ifdef INST_FETCH_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  inst_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  inst_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          has;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] inst;
  } ev_t;

  ent_t        mq[$];
  int          drop_m;
  bit          model_ok;
  logic [31:0] memq[$];
  ev_t         deliv[$];
  ev_t         grants[$];
  int          checks, errors, cyc_n;
  bit          resp_en, last_gnt;
  int          fcyc, acyc, rcyc;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", name, got, exp, cyc_n);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b (cycle %0d)", name, got, exp, cyc_n);
    end
  endtask

  // Reference model: buffer = queue of granted fetches in order.
  task automatic model_step();
    int          pend;
    int          n;
    bit          fill, used, e_req, e_valid;
    logic [31:0] e_inst, e_pc;
    pend = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (pend < 0 && !mq[i].has) pend = i;
    end
    fill    = bus.imem_rvalid_i && drop_m == 0 && pend >= 0;
    used    = bus.imem_rvalid_i && (drop_m > 0 || pend >= 0);
    e_req   = rst && !bus.flush && (mq.size() + drop_m < DEPTH);
    e_valid = mq.size() > 0 && mq[0].has;
    e_inst  = e_valid ? mq[0].inst : 32'h0;
    e_pc    = mq.size() > 0 ? mq[0].pc : 32'h0;
    if (BYP && !e_valid && fill && pend == 0) begin
      e_valid = 1'b1;
      e_inst  = bus.imem_rdata_i;
    end

    if (model_ok) begin
      chk1("req", bus.imem_req_o, e_req);
      chk1("stall", bus.fetch_stall_o, !(e_req && bus.imem_gnt_i));
      chk("addr", bus.imem_addr_o, bus.pc_i);
      chk1("id_valid", bus.id_valid_o, e_valid);
      if (e_valid) begin
        chk("id_inst", bus.id_inst_o, e_inst);
        chk("id_pc", bus.id_pc_o, e_pc);
      end
    end

    last_gnt = bus.imem_req_o && bus.imem_gnt_i;
    if (last_gnt) begin
      grants.push_back('{cyc: cyc_n, pc: bus.imem_addr_o, inst: 32'h0});
      memq.push_back(bus.imem_addr_o);
    end
    if (bus.id_valid_o && bus.id_ready_i)
      deliv.push_back('{cyc: cyc_n, pc: bus.id_pc_o, inst: bus.id_inst_o});

    if (!rst) begin
      mq.delete();
      drop_m   = 0;
      model_ok = 1'b1;
    end else if (bus.flush) begin
      n = 0;
      foreach (mq[i]) if (!mq[i].has) n++;
      drop_m = drop_m + n - (used ? 1 : 0);
      mq.delete();
    end else begin
      if (bus.imem_rvalid_i) begin
        if (drop_m > 0) drop_m--;
        else if (pend >= 0) begin
          mq[pend].has  = 1'b1;
          mq[pend].inst = bus.imem_rdata_i;
        end
      end
      if (e_valid && bus.id_ready_i) void'(mq.pop_front());
      if (e_req && bus.imem_gnt_i) mq.push_back('{pc: bus.pc_i, inst: 32'h0, has: 1'b0});
    end
  endtask

  // One clock: check/advance model at negedge, then drive PC and memory.
  task automatic cyc();
    logic [31:0] a;
    @(negedge clk);
    cyc_n++;
    model_step();
    @(posedge clk);
    #1;
    if (last_gnt) bus.pc_i = bus.pc_i + 32'd4;
    if (resp_en && memq.size() > 0) begin
      a = memq.pop_front();
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = inst_of(a);
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'h0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc_n);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc_n = 0; model_ok = 1'b0; drop_m = 0;
    resp_en = 1'b1; last_gnt = 1'b0;
    rst = 1'b0;
    bus.pc_i = 32'h4; bus.flush = 1'b0; bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0; bus.id_ready_i = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) cyc();
    #1;
    chk1("reset_req", bus.imem_req_o, 1'b0);
    chk1("reset_stall", bus.fetch_stall_o, 1'b1);
    chk1("reset_valid", bus.id_valid_o, 1'b0);

    // Release: request at 0x4, then stream 0x4/0x8/0xC.
    rst = 1'b1; bus.id_ready_i = 1'b1; bus.imem_gnt_i = 1'b1;
    #1;
    chk1("first_req", bus.imem_req_o, 1'b1);
    chk("first_addr", bus.imem_addr_o, 32'h4);
    deliv.delete(); grants.delete();
    repeat (3) cyc();
    bus.imem_gnt_i = 1'b0;
    repeat (3) cyc();
    chk("stream_grants", 32'(grants.size()), 32'd3);
    chk("stream_count", 32'(deliv.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < deliv.size()) begin
        chk("stream_pc", deliv[i].pc, 32'(4 + 4 * i));
        chk("stream_cycle", 32'(deliv[i].cyc), 32'(4 + LAT + i));
      end
    end

    // Memory withholds grant for 5 cycles.
    grants.delete();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk1("memstall_stall", bus.fetch_stall_o, 1'b1);
      chk("memstall_addr", bus.imem_addr_o, 32'h10);
    end
    chk("memstall_grants", 32'(grants.size()), 32'd0);

    // Flush with 0x10 and 0x14 still outstanding; redirect to 0x40.
    resp_en = 1'b0; bus.imem_gnt_i = 1'b1;
    repeat (2) cyc();
    bus.flush = 1'b1; resp_en = 1'b1;
    #1;
    chk1("flush_req", bus.imem_req_o, 1'b0);
    chk1("flush_stall", bus.fetch_stall_o, 1'b1);
    fcyc = cyc_n + 1;
    deliv.delete();
    cyc();
    bus.flush = 1'b0; bus.pc_i = 32'h40;
    repeat (6) cyc();
    bus.imem_gnt_i = 1'b0;
    repeat (4) cyc();
    chk("flush_count", 32'(deliv.size()), 32'd6);
    if (deliv.size() >= 2) begin
      chk("flush_first_pc", deliv[0].pc, 32'h40);
      chk("flush_first_inst", deliv[0].inst, 32'hC0DE_0053);
      chk("flush_first_cycle", 32'(deliv[0].cyc), 32'(fcyc + 2 + LAT));
      chk("flush_second_pc", deliv[1].pc, 32'h44);
    end

    // Flush in the same cycle as the only outstanding response.
    bus.imem_gnt_i = 1'b1;
    cyc();
    bus.imem_gnt_i = 1'b0; bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0; bus.pc_i = 32'h80; bus.imem_gnt_i = 1'b1;
    deliv.delete();
    acyc = cyc_n + 1;
    cyc();
    bus.imem_gnt_i = 1'b0;
    repeat (3) cyc();
    chk("flushrsp_count", 32'(deliv.size()), 32'd1);
    if (deliv.size() >= 1) begin
      chk("flushrsp_pc", deliv[0].pc, 32'h80);
      chk("flushrsp_inst", deliv[0].inst, 32'hC0DE_0093);
      chk("flushrsp_cycle", 32'(deliv[0].cyc), 32'(acyc + LAT));
    end

    // Full buffer with decode stalled, then a single retire.
    bus.pc_i = 32'h100; bus.id_ready_i = 1'b0; bus.imem_gnt_i = 1'b1;
    grants.delete();
    repeat (8) cyc();
    chk("full_grants", 32'(grants.size()), 32'd4);
    #1;
    chk1("full_req", bus.imem_req_o, 1'b0);
    chk1("full_stall", bus.fetch_stall_o, 1'b1);
    bus.id_ready_i = 1'b1;
    rcyc = cyc_n + 1;
    grants.delete();
    cyc();
    bus.id_ready_i = 1'b0;
    repeat (3) cyc();
    chk("refill_grants", 32'(grants.size()), 32'd1);
    if (grants.size() >= 1) begin
      chk("refill_cycle", 32'(grants[0].cyc), 32'(rcyc + 1));
      chk("refill_pc", grants[0].pc, 32'h110);
    end
    bus.id_ready_i = 1'b1; bus.imem_gnt_i = 1'b0;
    deliv.delete();
    repeat (6) cyc();
    chk("drain_count", 32'(deliv.size()), 32'd4);
    if (deliv.size() >= 4) begin
      chk("drain_first_pc", deliv[0].pc, 32'h104);
      chk("drain_last_pc", deliv[3].pc, 32'h110);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
